pe_sub_f32_seq: RTL and testbench

PE_SUB_F32_SEQ -- requirements
Module: pe_sub_f32_seq

---
 rtl/pe_sub_f32_seq.sv | 189 ++++++++++++++++++
 tb/tb_pe_sub_f32_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sub_f32_seq.sv
// Multi-cycle binary32 subtractor (diff = a - b), round-toward-zero, one operation in flight.
// Denormal inputs are flushed to zero; NORM normalises one bit per cycle.
module pe_sub_f32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE} state_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    state_t state, state_nxt;

    logic [31:0] ra, rb;
    logic        sgn, eff_sub, zero_q, flush_q;
    logic [8:0]  ex;
    logic [7:0]  exp_b;
    logic [26:0] mant, mb;
    logic [31:0] res_q;

    // unpack view of the captured operands; b's sign is inverted here
    logic [7:0]  ea_i, eb_i;
    logic [22:0] fa_i, fb_i;
    logic        sa_i, sb_i, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;
    logic        special;
    logic [31:0] spec_res;

    always_comb begin
        ea_i   = ra[30:23];
        eb_i   = rb[30:23];
        fa_i   = ra[22:0];
        fb_i   = rb[22:0];
        sa_i   = ra[31];
        sb_i   = ~rb[31];
        a_zero = (ea_i == 8'd0);
        b_zero = (eb_i == 8'd0);
        a_nan  = (ea_i == 8'hFF) && (fa_i != 23'd0);
        b_nan  = (eb_i == 8'hFF) && (fb_i != 23'd0);
        a_inf  = (ea_i == 8'hFF) && (fa_i == 23'd0);
        b_inf  = (eb_i == 8'hFF) && (fb_i == 23'd0);
        swap   = (rb[30:0] > ra[30:0]);
        special  = 1'b1;
        spec_res = 32'd0;
        if (a_nan || b_nan)
            spec_res = QNAN;
        else if (a_inf && b_inf)
            spec_res = (sa_i != sb_i) ? QNAN : ra;
        else if (a_inf)
            spec_res = ra;
        else if (b_inf)
            spec_res = {sb_i, rb[30:0]};
        else if (a_zero && b_zero)
            spec_res = {sa_i & sb_i, 31'd0};
        else if (b_zero)
            spec_res = ra;
        else if (a_zero)
            spec_res = {sb_i, rb[30:0]};
        else
            special = 1'b0;
    end

    // alignment of the smaller mantissa with guard/round/sticky collapse
    logic [7:0]  sh_amt;
    logic [26:0] mb_shr, mb_al;
    logic        lost;

    always_comb begin
        sh_amt = ex[7:0] - exp_b;
        mb_shr = mb >> sh_amt;
        lost   = |(mb & ~(27'h7FFFFFF << sh_amt));
        if (sh_amt >= 8'd27)
            mb_al = 27'd1;
        else
            mb_al = {mb_shr[26:1], mb_shr[0] | lost};
    end

    logic [27:0] sum;

    always_comb begin
        if (eff_sub)
            sum = {1'b0, mant} - {1'b0, mb};
        else
            sum = {1'b0, mant} + {1'b0, mb};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = UNPACK;
            UNPACK:  state_nxt = special ? DONE : ALIGN;
            ALIGN:   state_nxt = ADD;
            ADD:     state_nxt = NORM;
            NORM:    if ((mant == 27'd0) || mant[26] || (ex <= 9'd1)) state_nxt = PACK;
            PACK:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra      <= 32'd0;
            rb      <= 32'd0;
            sgn     <= 1'b0;
            eff_sub <= 1'b0;
            zero_q  <= 1'b0;
            flush_q <= 1'b0;
            ex      <= 9'd0;
            exp_b   <= 8'd0;
            mant    <= 27'd0;
            mb      <= 27'd0;
            res_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra <= a;
                    rb <= b;
                end
                UNPACK: begin
                    zero_q  <= 1'b0;
                    flush_q <= 1'b0;
                    if (special) begin
                        res_q <= spec_res;
                    end else begin
                        sgn     <= swap ? sb_i : sa_i;
                        eff_sub <= (sa_i != sb_i);
                        ex      <= {1'b0, swap ? eb_i : ea_i};
                        exp_b   <= swap ? ea_i : eb_i;
                        mant    <= {1'b1, swap ? fb_i : fa_i, 3'b000};
                        mb      <= {1'b1, swap ? fa_i : fb_i, 3'b000};
                    end
                end
                ALIGN: mb <= mb_al;
                ADD: begin
                    if (sum[27]) begin
                        mant <= {sum[27:2], sum[1] | sum[0]};
                        ex   <= ex + 9'd1;
                    end else begin
                        mant <= sum[26:0];
                    end
                end
                NORM: begin
                    if (mant == 27'd0)
                        zero_q <= 1'b1;
                    else if (!mant[26]) begin
                        if (ex <= 9'd1)
                            flush_q <= 1'b1;
                        else begin
                            mant <= {mant[25:0], 1'b0};
                            ex   <= ex - 9'd1;
                        end
                    end
                end
                PACK: begin
                    if (zero_q)
                        res_q <= 32'd0;
                    else if (flush_q)
                        res_q <= {sgn, 31'd0};
                    else if (ex >= 9'd255)
                        res_q <= {sgn, 31'h7F7FFFFF};
                    else
                        res_q <= {sgn, ex[7:0], mant[25:3]};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign diff      = res_q;

endmodule

// File: tb/tb_pe_sub_f32_seq.sv
// Self-checking bench for pe_sub_f32_seq: directed corner cases plus random operands
// checked against an exact-integer reference of truncated a - b.
module tb_pe_sub_f32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] diff;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    pe_sub_f32_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact difference on scaled integers, truncated toward zero.
    function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output int lat);
        logic        sx, sy, sbig, ssml;
        int          ex_, ey_, ebig, esml, d, p, e;
        logic [22:0] fx, fy;
        logic [127:0] mbig, msml, SA, SB, R, sh;
        sx  = x[31];
        sy  = ~y[31];
        ex_ = int'(x[30:23]);
        ey_ = int'(y[30:23]);
        fx  = x[22:0];
        fy  = y[22:0];
        lat = 2;
        if ((ex_ == 255 && fx != 0) || (ey_ == 255 && fy != 0)) r = 32'h7FC00000;
        else if (ex_ == 255 && ey_ == 255) r = (sx != sy) ? 32'h7FC00000 : x;
        else if (ex_ == 255) r = x;
        else if (ey_ == 255) r = {sy, y[30:0]};
        else if (ex_ == 0 && ey_ == 0) r = {sx & sy, 31'd0};
        else if (ey_ == 0) r = x;
        else if (ex_ == 0) r = {sy, y[30:0]};
        else begin
            lat = 6;
            if (y[30:0] > x[30:0]) begin
                sbig = sy; ebig = ey_; mbig = {104'd1, fy};
                ssml = sx; esml = ex_; msml = {104'd1, fx};
            end else begin
                sbig = sx; ebig = ex_; mbig = {104'd1, fx};
                ssml = sy; esml = ey_; msml = {104'd1, fy};
            end
            d  = ebig - esml;
            SA = mbig << 60;
            SB = (d > 60) ? 128'd1 : ((msml << 60) >> d);
            R  = (sbig == ssml) ? SA + SB : SA - SB;
            if (R == 0) r = 32'd0;
            else begin
                p = 0;
                for (int i = 0; i < 128; i++) if (R[i]) p = i;
                e = ebig + p - 83;
                if (e < 1) begin
                    r   = {sbig, 31'd0};
                    lat = 6 + ebig - 1;
                end else if (e >= 255) begin
                    r = {sbig, 31'h7F7FFFFF};
                end else begin
                    sh  = R >> (p - 23);
                    r   = {sbig, 8'(e), sh[22:0]};
                    lat = 6 + ((p < 83) ? 83 - p : 0);
                end
            end
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_);
        logic [31:0] er;
        int          el, lat;
        bit          done;
        ref_sub(ta, tb_, er, el);
        a = ta; b = tb_; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat  = 1;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (out_valid) done = 1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        check({tag, "_valid"}, 32'(done), 32'd1);
        check({tag, "_diff"}, diff, er);
        check({tag, "_lat"}, 32'(lat), 32'(el));
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] fp(input int s, input int e, input int f);
        return {1'(s), 8'(e), 23'(f)};
    endfunction

    initial begin
        logic [31:0] ra_, rb_;
        int          ea, eb, sa;
        bit          ov_seen, done;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", diff, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed arithmetic cases
        do_op("3m1", 32'h40400000, 32'h3F800000);
        do_op("1m1", 32'h3F800000, 32'h3F800000);
        do_op("carry", 32'h3F800000, 32'hBF800000);
        do_op("sticky", 32'h3F800000, 32'h30800000);
        do_op("long_norm", 32'h3F800000, 32'h3F7FFFFF);
        do_op("ovf", 32'h7F7FFFFF, 32'hFF7FFFFF);
        do_op("uflow", 32'h00C00000, 32'h00800000);

        // specials and zeros
        do_op("inf_inf", 32'h7F800000, 32'h7F800000);
        do_op("nan_a", 32'h7FC00000, 32'h12345678);
        do_op("nan_b", 32'h3F800000, 32'hFF800001);
        do_op("inf_ninf", 32'h7F800000, 32'hFF800000);
        do_op("fin_inf", 32'h40000000, 32'h7F800000);
        do_op("nz_pz", 32'h80000000, 32'h00000000);
        do_op("pz_pz", 32'h00000000, 32'h00000000);
        do_op("bzero", 32'hC0A00000, 32'h80000000);
        do_op("azero", 32'h00000000, 32'h40A00000);
        do_op("denorm_b", 32'h40A00000, 32'h00012345);

        // stall in DONE with a competing request that must not be captured
        a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (out_valid) done = 1;
        end
        check("stall_reach", 32'(done), 32'd1);
        a = 32'h41200000; b = 32'h3F800000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_diff", diff, 32'h40000000);
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("release_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        check("release_valid", 32'(out_valid), 32'd0);

        // reset during normalisation aborts cleanly
        ov_seen = 0;
        a = 32'h3F800000; b = 32'h3F7FFFFF; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
        end
        check("norm_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_diff", diff, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
        end
        check("abort_no_pulse", 32'(ov_seen), 32'd0);
        do_op("after_abort", 32'h40400000, 32'h3F800000);

        // randomized operands in several regimes
        for (int i = 0; i < 48; i++) begin
            case (i % 4)
                0: begin
                    ra_ = $urandom;
                    rb_ = $urandom;
                end
                1: begin
                    ea  = int'($urandom_range(1, 254));
                    eb  = ea - int'($urandom_range(0, 30));
                    if (eb < 1) eb = 1;
                    ra_ = fp(int'($urandom_range(0, 1)), ea, int'($urandom));
                    rb_ = fp(int'($urandom_range(0, 1)), eb, int'($urandom));
                end
                2: begin
                    ea  = int'($urandom_range(1, 3));
                    sa  = int'($urandom_range(0, 1));
                    ra_ = fp(sa, ea, int'($urandom));
                    rb_ = fp(sa, ea + int'($urandom_range(0, 1)) - 1 + ((ea == 1) ? 1 : 0), int'($urandom));
                end
                default: begin
                    sa  = int'($urandom_range(0, 1));
                    ra_ = fp(sa, 254, int'($urandom));
                    rb_ = fp(1 - sa, int'($urandom_range(252, 254)), int'($urandom));
                end
            endcase
            do_op($sformatf("rnd%0d", i), ra_, rb_);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
